// File: rtl/cache_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared types and address-field helpers for the 4-set,
//            4-word-per-line direct-mapped data cache and its refill logic.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } refill_state_t;

  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 2;
  localparam int SET_W      = 2;
  localparam int TAG_W      = 26;

  // Word offset within a line: bits [3:2]
  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [31:0] a);
    return a[3:2];
  endfunction

  // Set index: bits [5:4]
  function automatic logic [SET_W-1:0] addr_set(input logic [31:0] a);
    return a[5:4];
  endfunction

  // Tag: bits [31:6]
  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:6];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_refill_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl_if
// Brief    : Pipeline, cache-line and data-memory signals of the refill
//            controller. "master" is the controller side, "slave" is the
//            pipeline/cache/memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_refill_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  cache_hit;
  logic                  stall;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic                  line_we;
  logic [DATA_WIDTH-1:0] line_d0;
  logic [DATA_WIDTH-1:0] line_d1;
  logic [DATA_WIDTH-1:0] line_d2;
  logic [DATA_WIDTH-1:0] line_d3;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [31:0]           miss_count;

  modport master (
    input  req_valid, req_addr, cache_hit, mem_ack, mem_rdata,
    output stall, cache_addr, line_we, line_d0, line_d1, line_d2, line_d3,
           mem_req, mem_addr, miss_count
  );

  modport slave (
    output req_valid, req_addr, cache_hit, mem_ack, mem_rdata,
    input  stall, cache_addr, line_we, line_d0, line_d1, line_d2, line_d3,
           mem_req, mem_addr, miss_count
  );
endinterface
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl
// Brief    : Load-miss handler. Stalls the pipeline on a miss, fetches the
//            four words of the line in order 0..3 over a req/ack handshake,
//            writes the whole line into the cache in one FILL cycle, then
//            lets the replayed access hit.
// Revision : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  cache_refill_ctrl_if.master  bus
);

  refill_state_t         state_q, state_d;
  logic [OFFSET_W-1:0]   word_idx_q, word_idx_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic [DATA_WIDTH-1:0] line_buf_q [LINE_WORDS];
  logic [DATA_WIDTH-1:0] line_buf_d [LINE_WORDS];
  logic [31:0]           miss_count_q, miss_count_d;

  localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

  // State register and datapath flops; reset discards any partial line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_idx_q   <= '0;
      miss_addr_q  <= '0;
      miss_count_q <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        line_buf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      miss_addr_q  <= miss_addr_d;
      miss_count_q <= miss_count_d;
      line_buf_q   <= line_buf_d;
    end
  end

  // Next-state and output decode; memory address is zero outside FETCH
  always_comb begin
    state_d        = state_q;
    word_idx_d     = word_idx_q;
    miss_addr_d    = miss_addr_q;
    miss_count_d   = miss_count_q;
    line_buf_d     = line_buf_q;
    bus.mem_req    = 1'b0;
    bus.mem_addr   = '0;
    bus.line_we    = 1'b0;
    bus.cache_addr = miss_addr_q;

    unique case (state_q)
      IDLE: begin
        bus.cache_addr = bus.req_addr;
        if (bus.req_valid && !bus.cache_hit) begin
          miss_addr_d = bus.req_addr;
          word_idx_d  = '0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {miss_addr_q[ADDR_WIDTH-1:4], word_idx_q, 2'b00};
        if (bus.mem_ack) begin
          line_buf_d[word_idx_q] = bus.mem_rdata;
          word_idx_d             = word_idx_q + 1'b1;
          if (word_idx_q == LAST_WORD) begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        bus.line_we = 1'b1;
        state_d     = IDLE;
        if (miss_count_q != '1) begin
          miss_count_d = miss_count_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.stall      = rst_n && ((state_q != IDLE) || (bus.req_valid && !bus.cache_hit));
  assign bus.line_d0    = line_buf_q[0];
  assign bus.line_d1    = line_buf_q[1];
  assign bus.line_d2    = line_buf_q[2];
  assign bus.line_d3    = line_buf_q[3];
  assign bus.miss_count = miss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_ctrl
// Brief    : Scoreboard bench for cache_refill_ctrl. Stimulus pushes the
//            expected fetch addresses and line contents; monitors pop and
//            compare whenever the controller requests memory or writes a line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_refill_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  cache_refill_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Data memory contents: line 0x20 holds 0xA0..0xA3, elsewhere a hash of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h2) return 32'hA0 + {30'd0, a[3:2]};
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign bus.mem_rdata = mem_word(bus.mem_addr);

  // Tag store of the cache being refilled
  logic        vld_m [4];
  logic [25:0] tag_m [4];

  function automatic bit model_hit(input logic [31:0] a);
    return vld_m[addr_set(a)] && (tag_m[addr_set(a)] == addr_tag(a));
  endfunction

  // Scoreboard queues
  typedef struct {
    logic [31:0]       addr;
    logic [3:0][31:0]  d;
  } line_t;

  line_t       exp_lines [$];
  logic [31:0] exp_fetch [$];
  int          n_refills = 0;

  task automatic push_miss(input logic [31:0] a);
    line_t e;
    e.addr = a;
    for (int k = 0; k < 4; k++) begin
      e.d[k] = mem_word({a[31:4], 4'h0} + 32'(4 * k));
      exp_fetch.push_back({a[31:4], 4'h0} + 32'(4 * k));
    end
    exp_lines.push_back(e);
    n_refills++;
  endtask

  // Memory responder: 0 = ack always, 1 = ack every 3rd cycle, 2 = random
  int ack_mode = 0;
  int ack_cnt  = 0;
  int waits    = 0;

  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      case (ack_mode)
        0: bus.mem_ack = 1'b1;
        1: begin
          if (ack_cnt == 2) begin
            bus.mem_ack = 1'b1;
            ack_cnt = 0;
          end else begin
            bus.mem_ack = 1'b0;
            ack_cnt++;
            waits++;
          end
        end
        default: begin
          bus.mem_ack = ($urandom_range(2) == 0);
          if (!bus.mem_ack) waits++;
        end
      endcase
    end else begin
      ack_cnt = 0;
      bus.mem_ack = (ack_mode == 0) ? 1'b1 : 1'($urandom_range(1));
    end
  end

  // Monitor: line writes and memory requests against the scoreboard
  always @(negedge clk) begin
    line_t e;
    #2;
    if (rst_n === 1'b1 && bus.line_we === 1'b1) begin
      if (exp_lines.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL line_we_unexpected: got a line write, required none at %0t", $time);
      end else begin
        e = exp_lines.pop_front();
        chk("fill_cache_addr", bus.cache_addr, e.addr);
        chk("fill_d0", bus.line_d0, e.d[0]);
        chk("fill_d1", bus.line_d1, e.d[1]);
        chk("fill_d2", bus.line_d2, e.d[2]);
        chk("fill_d3", bus.line_d3, e.d[3]);
        vld_m[addr_set(e.addr)] = 1'b1;
        tag_m[addr_set(e.addr)] = addr_tag(e.addr);
      end
    end
    if (rst_n === 1'b1 && bus.mem_req === 1'b1) begin
      if (exp_fetch.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mem_req_unexpected: got request to 0x%08h, required none", bus.mem_addr);
      end else if (bus.mem_ack === 1'b1) begin
        chk("fetch_addr", bus.mem_addr, exp_fetch.pop_front());
      end else begin
        chk("fetch_hold", bus.mem_addr, exp_fetch[0]);
      end
    end
  end

  // One miss (optionally followed by a second miss presented at cycle b_at)
  task automatic do_seq(input logic [31:0] a, input logic [31:0] b, input int b_at,
                        input bit scramble);
    int stalls = 0;
    int w0     = waits;
    int expn;
    bit done   = 1'b0;
    push_miss(a);
    if (b_at > 0) push_miss(b);
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = (b_at > 0 && k >= b_at) ? b : a;
      if (scramble && k >= 1 && k <= 4) begin
        bus.req_addr  = $urandom;
        bus.req_valid = 1'($urandom_range(1));
      end
      bus.cache_hit = model_hit(bus.req_addr);
      #1;
      if (bus.stall === 1'b1) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL stall_timeout: got stall still high after 300 cycles, required release");
    end
    expn = ((b_at > 0) ? 12 : 6) + (waits - w0);
    chk("stall_cycles", 32'(stalls), 32'(expn));
    chk("miss_count", bus.miss_count, 32'(n_refills));
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.cache_hit = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_miss_count", bus.miss_count, 32'd0);
    exp_lines.delete();
    exp_fetch.delete();
    n_refills = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required completion within 200 us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      vld_m[i] = 1'b0;
      tag_m[i] = '0;
    end
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.cache_hit = 1'b0;
    bus.mem_ack   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_line_we", 32'(bus.line_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_miss_count", bus.miss_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_addr = 32'h1234_5678;
    #1;
    chk("idle_cache_addr", bus.cache_addr, 32'h1234_5678);

    // Cold miss, zero-wait
    ack_mode = 0;
    do_seq(32'h0000_0024, 32'h0, 0, 1'b0);

    // Hits: no stall, no memory traffic, no line write
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = $urandom;
      bus.cache_hit = 1'b1;
      #1;
      chk("hit_stall", 32'(bus.stall), 32'd0);
      chk("hit_mem_req", 32'(bus.mem_req), 32'd0);
      chk("hit_line_we", 32'(bus.line_we), 32'd0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.cache_hit = 1'b0;

    // Wait states: ack every third cycle
    ack_mode = 1;
    do_seq(32'h0000_01C8, 32'h0, 0, 1'b0);

    // Reset after the second ack of a refill
    ack_mode = 0;
    push_miss(32'h0000_00C0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_00C0;
      bus.cache_hit = model_hit(bus.req_addr);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("stall_in_reset", 32'(bus.stall), 32'd0);
    @(negedge clk);
    #1;
    chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
    chk("abort_line_we", 32'(bus.line_we), 32'd0);
    chk("abort_miss_count", bus.miss_count, 32'd0);
    chk("abort_mem_addr", bus.mem_addr, 32'd0);
    exp_lines.delete();
    exp_fetch.delete();
    n_refills = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk("abort_idle_stall", 32'(bus.stall), 32'd0);
    do_seq(32'h0000_00C0, 32'h0, 0, 1'b0);

    // Back-to-back misses from a cleared counter
    do_reset();
    do_seq(32'h0000_0040, 32'h0000_0100, 6, 1'b0);

    // Request address wanders during the refill
    do_seq(32'h0000_0040, 32'h0, 0, 1'b1);

    // Random loads with random memory latency
    ack_mode = 2;
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      a = ($urandom_range(15) << 4) | ($urandom_range(3) << 2);
      if (model_hit(a)) begin
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.cache_hit = 1'b1;
        #1;
        chk("rand_hit_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.cache_hit = 1'b0;
      end else begin
        do_seq(a, 32'h0, 0, 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    chk("lines_pending", 32'(exp_lines.size()), 32'd0);
    chk("fetches_pending", 32'(exp_fetch.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
